serial_adder: RTL and testbench

- Parametrised multi-cycle successor to the combinational HA/FA adder cells.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, through one DIGIT-wide full-adder slice and a registered carry.
- Start/busy/done handshake.
- Provides carry-out and signed-overflow flags.
- Used where a wide adder must be traded for area and latency in the datapath labs.

---
 rtl/serial_adder.sv | 205 ++++++++++++++++++++
 tb/tb_serial_adder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that processes DIGIT bits of two WIDTH-bit
// operands per clock through one DIGIT-wide full-adder slice and a registered
// carry. It uses a start/busy/done handshake and reports carry-out and signed
// overflow of the last completed result.
//
// Optional build macro: SERIAL_ADDER_SUB_EN
//   defined   - sub=1 at start computes a - b (B inverted, carry-in forced 1).
//   undefined - sub is accepted on the port but has no effect; always a+b+Cin.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             Cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic             accept_s;
    logic             step_s;
    logic             last_s;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;
    logic             ovf_r;

    logic             eff_sub_s;
    logic [WIDTH-1:0] b_cap_s;
    logic             cin_cap_s;

    logic [DIGIT-1:0] a_lo_s;
    logic [DIGIT-1:0] b_lo_s;
    logic [DIGIT-1:0] slice_sum_s;
    logic             slice_c_s;
    logic             msb_cin_s;
    logic [WIDTH-1:0] res_next_s;

`ifdef SERIAL_ADDER_SUB_EN
    assign eff_sub_s = sub;
`else
    // Port kept for interface stability; the term is constant zero.
    assign eff_sub_s = sub & 1'b0;
`endif

    // Subtraction is a + ~b + 1, so B is inverted and the carry forced high.
    assign b_cap_s   = b ^ {WIDTH{eff_sub_s}};
    assign cin_cap_s = eff_sub_s ? 1'b1 : Cin;

    // One DIGIT-wide full-adder slice fed by the low digits and carry register.
    assign a_lo_s = a_r[DIGIT-1:0];
    assign b_lo_s = b_r[DIGIT-1:0];
    assign {slice_c_s, slice_sum_s} = {1'b0, a_lo_s} + {1'b0, b_lo_s}
                                      + {{DIGIT{1'b0}}, carry_r};

    // Carry into the slice MSB recovered from the sum bit: c = s ^ a ^ b.
    assign msb_cin_s = a_lo_s[DIGIT-1] ^ b_lo_s[DIGIT-1] ^ slice_sum_s[DIGIT-1];

    // New digit enters at the top of the result; after STEPS shifts it is aligned.
    assign res_next_s = (res_r >> DIGIT) | (WIDTH'(slice_sum_s) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode plus accept/step/last strobes for the datapath.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, step counter and partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b_cap_s;
            carry_r <= cin_cap_s;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
        end else if (step_s) begin
            a_r     <= a_r >> DIGIT;
            b_r     <= b_r >> DIGIT;
            carry_r <= slice_c_s;
            cnt_r   <= last_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            res_r   <= res_next_s;
        end else begin
            a_r     <= a_r;
            b_r     <= b_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
            res_r   <= res_r;
        end
    end

    // Handshake flags: busy spans the RUN cycles, done pulses once after the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (last_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Result and flags update only on the final RUN edge and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r    <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_s) begin
            s_r    <= res_next_s;
            cout_r <= slice_c_s;
            ovf_r  <= msb_cin_s ^ slice_c_s;
        end else begin
            s_r    <= s_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign Cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 with DIGIT=1 and DIGIT=4).
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       Cin;
    logic       sub;

    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       Cout;
    logic       ovf;

    logic       busy4;
    logic       done4;
    logic [7:0] s4;
    logic       cout4;
    logic       ovf4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Cin(Cin), .sub(sub),
        .busy(busy), .done(done), .s(s), .Cout(Cout), .ovf(ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .Cin(Cin), .sub(sub),
        .busy(busy4), .done(done4), .s(s4), .Cout(cout4), .ovf(ovf4)
    );

    // Drives one operation on the DIGIT=1 instance and returns when done is seen.
    // done_at counts negedges after the accepting edge (0 means it never came).
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                         input logic isub, output int done_at, output logic [7:0] rs,
                         output logic rc, output logic ro);
        @(negedge clk);
        a = ia; b = ib; Cin = icin; sub = isub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_at = 0; rs = 8'h00; rc = 1'b0; ro = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i > 1) @(negedge clk);
            if (done) begin
                done_at = i; rs = s; rc = Cout; ro = ovf;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; Cin = 1'b0; sub = 1'b0;
        #12;
        checks++;
        if ({busy, done, s, Cout, ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_d1: got %h expected 000", {busy, done, s, Cout, ovf});
        end
        checks++;
        if ({busy4, done4, s4, cout4, ovf4} !== 12'h000) begin
            failures++;
            $display("FAIL reset_d4: got %h expected 000", {busy4, done4, s4, cout4, ovf4});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [8:0] busy_v;
        logic [8:0] done_v;
        logic [7:0] s_mid;
        logic [7:0] s_fin;
        logic       c_fin;
        logic       o_fin;
        @(negedge clk);
        a = 8'h5A; b = 8'h33; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_mid = 8'h00; s_fin = 8'h00; c_fin = 1'b0; o_fin = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            busy_v[i] = busy;
            done_v[i] = done;
            if (i == 7) s_mid = s;
            if (i == 8) begin s_fin = s; c_fin = Cout; o_fin = ovf; end
        end
        checks++;
        if (busy_v !== 9'b0_1111_1111) begin
            failures++; $display("FAIL basic_busy: got %b expected 011111111", busy_v);
        end
        checks++;
        if (done_v !== 9'b1_0000_0000) begin
            failures++; $display("FAIL basic_done: got %b expected 100000000", done_v);
        end
        checks++;
        if (s_mid !== 8'h00) begin
            failures++; $display("FAIL basic_s_stable: got %h expected 00", s_mid);
        end
        checks++;
        if ({s_fin, c_fin, o_fin} !== {8'h8D, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL basic_result: got s=%h c=%b o=%b expected s=8d c=0 o=1", s_fin, c_fin, o_fin);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({done, s} !== {1'b0, 8'h8D}) begin
            failures++; $display("FAIL basic_hold: got done=%b s=%h expected done=0 s=8d", done, s);
        end
    endtask

    task automatic test_carry;
        int         d_at;
        logic [7:0] rs;
        logic       rc;
        logic       ro;
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, d_at, rs, rc, ro);
        checks++;
        if ({d_at[7:0], rs, rc, ro} !== {8'd9, 8'h00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL carry_wrap: got at=%0d s=%h c=%b o=%b expected at=9 s=00 c=1 o=0", d_at, rs, rc, ro);
        end
        do_op(8'h7F, 8'h00, 1'b1, 1'b0, d_at, rs, rc, ro);
        checks++;
        if ({d_at[7:0], rs, rc, ro} !== {8'd9, 8'h80, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL carry_cin_ovf: got at=%0d s=%h c=%b o=%b expected at=9 s=80 c=0 o=1", d_at, rs, rc, ro);
        end
    endtask

    task automatic test_digit4;
        int         d_at;
        logic [1:0] busy_v;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; Cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d_at = 0; busy_v = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            if (i > 1) @(negedge clk);
            if (i <= 2) busy_v[i-1] = busy4;
            if (done4) begin d_at = i; break; end
        end
        checks++;
        if (d_at !== 3) begin
            failures++; $display("FAIL d4_latency: got %0d expected 3", d_at);
        end
        checks++;
        if (busy_v !== 2'b11) begin
            failures++; $display("FAIL d4_busy: got %b expected 11", busy_v);
        end
        checks++;
        if ({s4, cout4, ovf4} !== {8'hFF, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL d4_result: got s=%h c=%b o=%b expected s=ff c=1 o=0", s4, cout4, ovf4);
        end
        // let the DIGIT=1 instance finish the same operation
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int         first_at;
        int         second_at;
        logic [9:0] r1;
        logic [9:0] r2;
        logic [1:0] gap;
        @(negedge clk);
        a = 8'h12; b = 8'h34; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        first_at = 0; second_at = 0; r1 = 10'h0; r2 = 10'h0; gap = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 3) begin a = 8'h40; b = 8'h41; end
            if (i == 4) start = 1'b0;
            if (i == 5) start = 1'b1;
            if (i == 10) begin gap = {busy, done}; start = 1'b0; end
            if (done && first_at == 0) begin
                first_at = i; r1 = {s, Cout, ovf};
            end else if (done && second_at == 0) begin
                second_at = i; r2 = {s, Cout, ovf};
            end
        end
        checks++;
        if ({first_at[7:0], r1} !== {8'd9, 8'h46, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first: got at=%0d res=%h expected at=9 res=118", first_at, r1);
        end
        checks++;
        if (gap !== 2'b10) begin
            failures++; $display("FAIL b2b_no_idle: got busy,done=%b expected 10", gap);
        end
        checks++;
        if ({second_at[7:0], r2} !== {8'd18, 8'h81, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL b2b_second: got at=%0d res=%h expected at=18 res=205", second_at, r2);
        end
    endtask

    task automatic test_reset_mid;
        int         d_at;
        logic [7:0] rs;
        logic       rc;
        logic       ro;
        int         stray;
        @(negedge clk);
        a = 8'h11; b = 8'h22; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, s, Cout, ovf} !== 12'h000) begin
            failures++;
            $display("FAIL midreset_clear: got %h expected 000", {busy, done, s, Cout, ovf});
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", stray);
        end
        do_op(8'h01, 8'h02, 1'b1, 1'b0, d_at, rs, rc, ro);
        checks++;
        if ({d_at[7:0], rs, rc, ro} !== {8'd9, 8'h04, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_next: got at=%0d s=%h c=%b o=%b expected at=9 s=04 c=0 o=0", d_at, rs, rc, ro);
        end
    endtask

    task automatic test_sub;
        int         d_at;
        logic [7:0] rs;
        logic       rc;
        logic       ro;
        logic [9:0] exp1;
        logic [9:0] exp2;
`ifdef SERIAL_ADDER_SUB_EN
        exp1 = {8'hF0, 1'b0, 1'b0};
        exp2 = {8'h7F, 1'b1, 1'b1};
`else
        exp1 = {8'h30, 1'b0, 1'b0};
        exp2 = {8'h82, 1'b0, 1'b0};
`endif
        do_op(8'h10, 8'h20, 1'b0, 1'b1, d_at, rs, rc, ro);
        checks++;
        if ({rs, rc, ro} !== exp1 || d_at !== 9) begin
            failures++;
            $display("FAIL sub_first: got at=%0d res=%h expected at=9 res=%h", d_at, {rs, rc, ro}, exp1);
        end
        do_op(8'h80, 8'h01, 1'b1, 1'b1, d_at, rs, rc, ro);
        checks++;
        if ({rs, rc, ro} !== exp2 || d_at !== 9) begin
            failures++;
            $display("FAIL sub_second: got at=%0d res=%h expected at=9 res=%h", d_at, {rs, rc, ro}, exp2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_digit4();
        test_back_to_back();
        test_reset_mid();
        test_sub();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
